// File: rtl/core_pkg.sv
// Shared core sizing and the reorder-buffer entry layout.
package core_pkg;

  localparam int unsigned ROB_ENTRIES = 16;
  localparam int unsigned ISSUE_WIDTH = 2;
  localparam int unsigned PREGS       = 64;
  localparam int unsigned PHYS_TAG_W  = $clog2(PREGS);

  typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_idx_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  mispredict;
    logic [4:0]            arch_rd;
    logic [PHYS_TAG_W-1:0] dst_phys;
    logic [PHYS_TAG_W-1:0] old_phys;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order completion tracker: circular buffer with multi-lane alloc/complete/commit.
// Optional ROB_PERF_CNT_EN adds retired-lane and alloc-stall counters.
module reorder_buffer
  import core_pkg::*;
#(
  parameter int unsigned ENTRIES = ROB_ENTRIES,
  parameter int unsigned ISSUE_W = ISSUE_WIDTH,
  parameter int unsigned TAG_W   = PHYS_TAG_W,
  localparam int unsigned IDXW   = $clog2(ENTRIES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ISSUE_W-1:0]             alloc_req,
  input  logic [ISSUE_W-1:0][4:0]        alloc_arch_rd,
  input  logic [ISSUE_W-1:0][TAG_W-1:0]  alloc_dst_phys,
  input  logic [ISSUE_W-1:0][TAG_W-1:0]  alloc_old_phys,
  output logic                           alloc_ok,
  output logic [ISSUE_W-1:0][IDXW-1:0]   alloc_rob_idx,
  input  logic [ISSUE_W-1:0]             cpl_valid,
  input  logic [ISSUE_W-1:0][IDXW-1:0]   cpl_rob_idx,
  input  logic                           br_cpl_valid,
  input  logic [IDXW-1:0]                br_cpl_rob_idx,
  input  logic                           br_mispredict,
  output logic [ISSUE_W-1:0]             commit_valid,
  output logic [ISSUE_W-1:0][IDXW-1:0]   commit_idx,
  output logic [ISSUE_W-1:0][4:0]        commit_arch_rd,
  output logic [ISSUE_W-1:0][TAG_W-1:0]  commit_dst_phys,
  output logic [ISSUE_W-1:0][TAG_W-1:0]  commit_old_phys,
  output logic                           commit_clear_all,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]                    perf_commit_cnt,
  output logic [31:0]                    perf_stall_cnt,
`endif
  output logic                           rob_full,
  output logic                           rob_empty
);

  rob_entry_t      rob_q [ENTRIES];
  rob_entry_t      rob_d [ENTRIES];
  logic [IDXW-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDXW:0]   count_q, count_d;

  // Lane i takes the slot after all lower requesting lanes.
  always_comb begin
    int unsigned n_req;
    n_req = 0;
    for (int i = 0; i < ISSUE_W; i++) begin
      alloc_rob_idx[i] = tail_q + IDXW'(n_req);
      n_req            = n_req + 32'(alloc_req[i]);
    end
    alloc_ok = ((ENTRIES - 32'(count_q)) >= n_req) && !commit_clear_all;
  end

  // A mispredicted branch ends the retire group: nothing younger retires with it.
  always_comb begin
    logic            prev_ok, prev_mis;
    logic [IDXW-1:0] idx;
    prev_ok  = 1'b1;
    prev_mis = 1'b0;
    for (int k = 0; k < ISSUE_W; k++) begin
      idx                = head_q + IDXW'(k);
      commit_valid[k]    = prev_ok & !prev_mis & rob_q[idx].valid & rob_q[idx].done;
      prev_ok            = commit_valid[k];
      prev_mis           = rob_q[idx].mispredict;
      commit_idx[k]      = commit_valid[k] ? idx : '0;
      commit_arch_rd[k]  = commit_valid[k] ? rob_q[idx].arch_rd : '0;
      commit_dst_phys[k] = commit_valid[k] ? rob_q[idx].dst_phys : '0;
      commit_old_phys[k] = commit_valid[k] ? rob_q[idx].old_phys : '0;
    end
    commit_clear_all = commit_valid[0] & rob_q[head_q].mispredict;
  end

  assign rob_full  = (count_q == (IDXW+1)'(ENTRIES));
  assign rob_empty = (count_q == '0);

  always_comb begin
    logic [IDXW:0] n_commit, n_alloc;
    rob_d    = rob_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    n_commit = '0;
    n_alloc  = '0;
    if (commit_clear_all) begin
      for (int i = 0; i < ENTRIES; i++) rob_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < ISSUE_W; k++) begin
        if (cpl_valid[k] && rob_q[cpl_rob_idx[k]].valid) rob_d[cpl_rob_idx[k]].done = 1'b1;
      end
      if (br_cpl_valid && rob_q[br_cpl_rob_idx].valid) begin
        rob_d[br_cpl_rob_idx].done       = 1'b1;
        rob_d[br_cpl_rob_idx].mispredict = br_mispredict;
      end
      for (int k = 0; k < ISSUE_W; k++) begin
        if (commit_valid[k]) begin
          rob_d[commit_idx[k]].valid = 1'b0;
          n_commit                   = n_commit + 1'b1;
        end
      end
      if (alloc_ok) begin
        for (int i = 0; i < ISSUE_W; i++) begin
          if (alloc_req[i]) begin
            rob_d[alloc_rob_idx[i]] = '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                        arch_rd: alloc_arch_rd[i],
                                        dst_phys: alloc_dst_phys[i],
                                        old_phys: alloc_old_phys[i]};
            n_alloc = n_alloc + 1'b1;
          end
        end
      end
      head_d  = head_q + n_commit[IDXW-1:0];
      tail_d  = tail_q + n_alloc[IDXW-1:0];
      count_d = count_q + n_alloc - n_commit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_q, perf_commit_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_commit_d = perf_commit_q;
    for (int k = 0; k < ISSUE_W; k++) perf_commit_d = perf_commit_d + 32'(commit_valid[k]);
    perf_stall_d = perf_stall_q + 32'((|alloc_req) && !alloc_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_commit_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_commit_q <= perf_commit_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_commit_cnt = perf_commit_q;
  assign perf_stall_cnt  = perf_stall_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (perf checks when ROB_PERF_CNT_EN is set).
module tb_reorder_buffer;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      alloc_req;
  logic [1:0][4:0] alloc_arch_rd;
  logic [1:0][5:0] alloc_dst_phys, alloc_old_phys;
  logic            alloc_ok;
  logic [1:0][3:0] alloc_rob_idx;
  logic [1:0]      cpl_valid;
  logic [1:0][3:0] cpl_rob_idx;
  logic            br_cpl_valid;
  logic [3:0]      br_cpl_rob_idx;
  logic            br_mispredict;
  logic [1:0]      commit_valid;
  logic [1:0][3:0] commit_idx;
  logic [1:0][4:0] commit_arch_rd;
  logic [1:0][5:0] commit_dst_phys, commit_old_phys;
  logic            commit_clear_all;
  logic            rob_full, rob_empty;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]     perf_commit_cnt, perf_stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  reorder_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_req        (alloc_req),
    .alloc_arch_rd    (alloc_arch_rd),
    .alloc_dst_phys   (alloc_dst_phys),
    .alloc_old_phys   (alloc_old_phys),
    .alloc_ok         (alloc_ok),
    .alloc_rob_idx    (alloc_rob_idx),
    .cpl_valid        (cpl_valid),
    .cpl_rob_idx      (cpl_rob_idx),
    .br_cpl_valid     (br_cpl_valid),
    .br_cpl_rob_idx   (br_cpl_rob_idx),
    .br_mispredict    (br_mispredict),
    .commit_valid     (commit_valid),
    .commit_idx       (commit_idx),
    .commit_arch_rd   (commit_arch_rd),
    .commit_dst_phys  (commit_dst_phys),
    .commit_old_phys  (commit_old_phys),
    .commit_clear_all (commit_clear_all),
`ifdef ROB_PERF_CNT_EN
    .perf_commit_cnt  (perf_commit_cnt),
    .perf_stall_cnt   (perf_stall_cnt),
`endif
    .rob_full         (rob_full),
    .rob_empty        (rob_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req    = 2'b00;
    cpl_valid    = 2'b00;
    br_cpl_valid = 1'b0;
  endtask

  // Lane 0 targets slot s, lane 1 slot s+1; dst = 32+slot, old = slot.
  task automatic set_alloc(input logic [1:0] req, input int s);
    alloc_req         = req;
    alloc_arch_rd[0]  = 5'(s);
    alloc_arch_rd[1]  = 5'(s + 1);
    alloc_dst_phys[0] = 6'(32 + s);
    alloc_dst_phys[1] = 6'(33 + s);
    alloc_old_phys[0] = 6'(s);
    alloc_old_phys[1] = 6'(s + 1);
  endtask

  task automatic cpl(input logic [1:0] v, input int a, input int b);
    cpl_valid      = v;
    cpl_rob_idx[0] = 4'(a);
    cpl_rob_idx[1] = 4'(b);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    idle();
    alloc_arch_rd  = '0;
    alloc_dst_phys = '0;
    alloc_old_phys = '0;
    cpl_rob_idx    = '0;
    br_cpl_rob_idx = '0;
    br_mispredict  = 1'b0;
    #12;
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_empty", rob_empty, 1);
    chk("rst_full", rob_full, 0);
    chk("rst_alloc_ok", alloc_ok, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_idx", commit_idx, 0);
    chk("rst_clear_all", commit_clear_all, 0);

    // 1: dual alloc from empty
    alloc_req      = 2'b11;
    alloc_arch_rd  = {5'd2, 5'd1};
    alloc_dst_phys = {6'd11, 6'd10};
    alloc_old_phys = {6'd2, 6'd1};
    #1;
    chk("t1_alloc_idx", alloc_rob_idx, 8'h10);
    chk("t1_alloc_ok", alloc_ok, 1);
    tick();
    idle();
    #1;
    chk("t1_not_empty", rob_empty, 0);
    chk("t1_no_commit", commit_valid, 0);

    // 2: out-of-order completion, in-order retire
    cpl(2'b01, 1, 0);
    tick();
    idle();
    #1;
    chk("t2_slot1_only", commit_valid, 0);
    cpl(2'b01, 0, 0);
    #1;
    chk("t2_same_cycle_invisible", commit_valid, 0);
    tick();
    idle();
    #1;
    chk("t2_commit_valid", commit_valid, 2'b11);
    chk("t2_commit_idx", commit_idx, 8'h10);
    chk("t2_commit_old", commit_old_phys, {6'd2, 6'd1});
    chk("t2_commit_dst", commit_dst_phys, {6'd11, 6'd10});
    chk("t2_commit_rd", commit_arch_rd, {5'd2, 5'd1});
    tick();
    chk("t2_drained", rob_empty, 1);
    chk("t2_drained_cv", commit_valid, 0);

    // 3: fill, reject, retire, wrap
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      set_alloc(2'b11, 2 * c);
      tick();
    end
    idle();
    #1;
    chk("t3_full", rob_full, 1);
    set_alloc(2'b01, 0);
    #1;
    chk("t3_reject_ok", alloc_ok, 0);
    chk("t3_reject_idx0", alloc_rob_idx[0], 0);
    tick();
    idle();
    cpl(2'b11, 0, 1);
    #1;
    chk("t3_still_full", rob_full, 1);
    tick();
    idle();
    set_alloc(2'b11, 0);
    #1;
    chk("t3_commit_valid", commit_valid, 2'b11);
    chk("t3_commit_old", commit_old_phys, {6'd1, 6'd0});
    chk("t3_no_reuse", alloc_ok, 0);
    tick();
    #1;
    chk("t3_wrap_ok", alloc_ok, 1);
    chk("t3_wrap_idx", alloc_rob_idx, 8'h10);
    tick();
    idle();
    #1;
    chk("t3_refull", rob_full, 1);

    // 4: mispredicted branch at head flushes
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      set_alloc(2'b11, 2 * c);
      tick();
    end
    set_alloc(2'b01, 6);
    tick();
    idle();
    cpl(2'b11, 0, 1);
    tick();
    idle();
    cpl(2'b11, 2, 6);
    #1;
    chk("t4_commit01", commit_valid, 2'b11);
    tick();
    idle();
    cpl(2'b11, 4, 5);
    br_cpl_valid   = 1'b1;
    br_cpl_rob_idx = 4'd3;
    br_mispredict  = 1'b1;
    #1;
    chk("t4_commit2", commit_valid, 2'b01);
    tick();
    idle();
    br_mispredict = 1'b0;
    set_alloc(2'b01, 9);
    cpl(2'b01, 3, 0);
    #1;
    chk("t4_br_commit", commit_valid, 2'b01);
    chk("t4_br_idx", commit_idx, 8'h03);
    chk("t4_clear_all", commit_clear_all, 1);
    chk("t4_alloc_blocked", alloc_ok, 0);
    tick();
    idle();
    #1;
    chk("t4_empty", rob_empty, 1);
    chk("t4_no_commit", commit_valid, 0);
    chk("t4_no_clear", commit_clear_all, 0);
    set_alloc(2'b11, 0);
    #1;
    chk("t4_ptrs_zero", alloc_rob_idx, 8'h10);
    idle();
    #1;

    // 5: async reset mid-stream with 5 entries
    set_alloc(2'b11, 0);
    tick();
    set_alloc(2'b11, 2);
    tick();
    set_alloc(2'b01, 4);
    tick();
    idle();
    cpl(2'b11, 0, 1);
    tick();
    idle();
    #1;
    chk("t5_pre_commit", commit_valid, 2'b11);
    reset = 1'b1;
    #1;
    chk("t5_async_cv", commit_valid, 0);
    chk("t5_async_old", commit_old_phys, 0);
    chk("t5_async_empty", rob_empty, 1);
    #1;
    reset = 1'b0;
    tick();

`ifdef ROB_PERF_CNT_EN
    // 6: perf counters
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      set_alloc(2'b11, 2 * c);
      tick();
    end
    set_alloc(2'b01, 0);
    for (int c = 0; c < 3; c++) tick();
    idle();
    cpl(2'b11, 0, 1);
    tick();
    idle();
    cpl(2'b11, 2, 3);
    tick();
    idle();
    tick();
    chk("t6_stall_cnt", perf_stall_cnt, 3);
    chk("t6_commit_cnt", perf_commit_cnt, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
